// File: rtl/uart_rx_ctrl_v2.sv
// UART receive controller: start/data/parity/stop framing with 3-point majority
// sampling, runtime frame format, error pulses and break detection.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | line idle, waiting for a falling edge on S_DATA
// START    | validating the start bit; a resolved 1 is a glitch
// DATA     | shifting data bits in, LSB first
// PARITY   | sampling and checking the parity bit
// STOP     | sampling one or two stop bits
// DONE     | one cycle: publish word or raise error/break pulses
// BRK_WAIT | break seen, waiting for the line to return high
module uart_rx_ctrl_v2 #(
  parameter int MAX_DATA_WIDTH = 9,
  parameter int PRESCALE_W     = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      S_DATA,
  input  logic [PRESCALE_W-1:0]     Prescale,
  input  logic [3:0]                data_len,
  input  logic                      parity_enable,
  input  logic                      parity_type,
  input  logic                      two_stop,
  output logic [MAX_DATA_WIDTH-1:0] P_DATA,
  output logic                      data_valid,
  output logic                      par_err,
  output logic                      stp_err,
  output logic                      brk_det,
  output logic                      busy
);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, DONE, BRK_WAIT
  } state_t;

  localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_TWO = PRESCALE_W'(2);

  state_t state, state_nxt;

  logic [PRESCALE_W-1:0]     presc_q, presc_even, half;
  logic [3:0]                len_q, len_clamped;
  logic                      par_en_q, par_type_q, two_stop_q;
  logic [PRESCALE_W-1:0]     edge_cnt;
  logic [3:0]                bit_cnt, first_stop, last_stop;
  logic                      samp_a, samp_b;
  logic [MAX_DATA_WIDTH-1:0] shreg;
  logic                      par_bad_q, stp_bad_q, par_bit_q, stop1_q;
  logic                      at_s0, at_s1, at_res, at_last, at_early;
  logic                      bit_val, is_break, start_frame;

  always_comb begin
    len_clamped = data_len;
    if (data_len < 4'd5)
      len_clamped = 4'd5;
    else if (data_len > 4'(MAX_DATA_WIDTH))
      len_clamped = 4'(MAX_DATA_WIDTH);
  end

  assign presc_even = Prescale - PRESCALE_W'(Prescale[0]);
  assign half       = presc_q >> 1;
  assign at_s0      = (edge_cnt == half - P_ONE);
  assign at_s1      = (edge_cnt == half);
  assign at_res     = (edge_cnt == half + P_ONE);
  assign at_last    = (edge_cnt == presc_q - P_ONE);
  assign at_early   = (edge_cnt == presc_q - P_TWO);
  assign first_stop = len_q + {3'b000, par_en_q} + 4'd1;
  assign last_stop  = first_stop + {3'b000, two_stop_q};

  // Third vote comes straight from the line at the resolve edge.
  assign bit_val  = (samp_a & samp_b) | (samp_a & S_DATA) | (samp_b & S_DATA);
  assign is_break = (shreg == '0) && (!par_en_q || !par_bit_q) && !stop1_q;
  assign busy     = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (!S_DATA) state_nxt = START;
      START: begin
        if (at_res && bit_val) state_nxt = IDLE;
        else if (at_last)      state_nxt = DATA;
      end
      DATA:     if (at_last && bit_cnt == len_q) state_nxt = par_en_q ? PARITY : STOP;
      PARITY:   if (at_last) state_nxt = STOP;
      // Leave one edge early so DONE can still catch an immediate start bit.
      STOP:     if (at_early && bit_cnt == last_stop) state_nxt = DONE;
      DONE: begin
        if (is_break)     state_nxt = BRK_WAIT;
        else if (!S_DATA) state_nxt = START;
        else              state_nxt = IDLE;
      end
      BRK_WAIT: if (S_DATA) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  assign start_frame = (state_nxt == START) && (state == IDLE || state == DONE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc_q    <= '0;
      len_q      <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      two_stop_q <= 1'b0;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      samp_a     <= 1'b0;
      samp_b     <= 1'b0;
      shreg      <= '0;
      par_bad_q  <= 1'b0;
      stp_bad_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      stop1_q    <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      brk_det    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      brk_det    <= 1'b0;
      if (start_frame) begin
        presc_q    <= presc_even;
        len_q      <= len_clamped;
        par_en_q   <= parity_enable;
        par_type_q <= parity_type;
        two_stop_q <= two_stop;
        edge_cnt   <= '0;
        bit_cnt    <= '0;
        shreg      <= '0;
        par_bad_q  <= 1'b0;
        stp_bad_q  <= 1'b0;
        par_bit_q  <= 1'b0;
        stop1_q    <= 1'b1;
      end else if (state inside {START, DATA, PARITY, STOP}) begin
        if (at_last) begin
          edge_cnt <= '0;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          edge_cnt <= edge_cnt + P_ONE;
        end
        if (at_s0) samp_a <= S_DATA;
        if (at_s1) samp_b <= S_DATA;
        if (at_res) begin
          case (state)
            DATA: begin
              for (int i = 0; i < MAX_DATA_WIDTH; i++)
                if (bit_cnt == 4'(i + 1)) shreg[i] <= bit_val;
            end
            PARITY: begin
              par_bit_q <= bit_val;
              par_bad_q <= (bit_val != ((^shreg) ^ par_type_q));
            end
            STOP: begin
              if (!bit_val) stp_bad_q <= 1'b1;
              if (bit_cnt == first_stop) stop1_q <= bit_val;
            end
            default: ;
          endcase
        end
      end else begin
        edge_cnt <= '0;
        bit_cnt  <= '0;
      end
      if (state == DONE) begin
        if (is_break) begin
          brk_det <= 1'b1;
        end else if (par_bad_q || stp_bad_q) begin
          par_err <= par_bad_q;
          stp_err <= stp_bad_q;
        end else begin
          P_DATA     <= shreg;
          data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_ctrl_v2.md
Name: uart_rx_ctrl_v2

Overview:
Self-contained UART receive controller. It merges the framing FSM, edge/bit counters, majority-vote sampler, deserializer and error checkers into one parametrised block. Compared with the first-generation RX FSM it adds:
- runtime-selectable data length
- even/odd parity
- 1 or 2 stop bits
- majority-vote sampling
- break detection
It sits between the 2-FF synchronizer on the RX pin and the RX FIFO write port.

Parameters:
MAX_DATA_WIDTH, 9, largest supported data length in bits (legal 5..9).
PRESCALE_W, 6, width of the Prescale input.

Ports:
CLK  input  1  receiver oversampling clock.
RST  input  1  asynchronous, active-low reset.
S_DATA  input  1  synchronized serial input, idle high.
Prescale  input  PRESCALE_W  oversampling ratio per bit; legal even values 8..32.
data_len  input  4  data bits per frame; legal 5..MAX_DATA_WIDTH.
parity_enable  input  1  1 = a parity bit follows the data bits.
parity_type  input  1  0 = even, 1 = odd.
two_stop  input  1  1 = two stop bits expected.
P_DATA  output  MAX_DATA_WIDTH  received word, LSB-aligned, unused upper bits 0.
data_valid  output  1  one-cycle pulse: P_DATA holds a new error-free frame.
par_err  output  1  one-cycle pulse: parity mismatch on the completed frame.
stp_err  output  1  one-cycle pulse: a stop bit sampled 0 (non-break frame).
brk_det  output  1  one-cycle pulse: break condition detected.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, shift register 0.
- Config latch: data_len, parity_enable, parity_type, two_stop and Prescale are captured on the IDLE->START transition. Changes mid-frame have no effect.
- Counters:
  - edge_cnt counts 0..Prescale-1 per bit, then wraps to 0 and increments bit_cnt.
  - bit_cnt is 0 for the start bit and increments through data, parity and stop bits.
- Sampling:
  - S_DATA is registered at edge_cnt = P/2-1, P/2 and P/2+1, where P is the latched Prescale.
  - Bit value = majority of the 3 samples, resolved at edge_cnt = P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE, BRK_WAIT.
  - IDLE: S_DATA=0 -> START, with edge_cnt=0 and bit_cnt=0 on entry.
  - START: if the resolved start bit is 1 (glitch), go to IDLE at the next cycle; no output pulse. Otherwise go to DATA at edge_cnt = P-1.
  - DATA: shift LSB-first. After data_len bits, at edge_cnt = P-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: compare the received bit with the XOR of the data bits, inverted when parity_type=1. Latch any mismatch. Go to STOP at edge_cnt = P-1.
  - STOP: sample 1 stop bit, or 2 if two_stop. A 0 on any stop bit latches the stop error. Leave for DONE at edge_cnt = P-2 of the last stop bit, so a back-to-back start edge is not missed.
  - DONE (1 cycle):
    - Break: all data bits 0, parity bit 0 (if enabled) and first stop bit 0 -> brk_det=1 only. par_err, stp_err and data_valid are suppressed, and the FSM goes to BRK_WAIT.
    - No error: P_DATA updated, data_valid=1.
    - Error: par_err and/or stp_err pulse, P_DATA not updated, data_valid=0.
    - Exit (non-break): S_DATA=0 -> START directly, else IDLE.
  - BRK_WAIT: stay until S_DATA=1, then go to IDLE. A falling edge cannot start a frame in this state.
- Error pulses: par_err and stp_err may pulse together in the same cycle.
- Illegal config:
  - data_len outside 5..MAX_DATA_WIDTH is clamped to the nearest legal value at latch.
  - An odd Prescale uses Prescale-1.
- Reset mid-frame: immediately returns to IDLE, all pulses 0, and P_DATA clears to 0.

Test Plan:
- Prescale=8, data_len=8, no parity, 1 stop, frame 0xA5 -> data_valid pulse, P_DATA=0x0A5, no error pulses; busy low one cycle after DONE.
- data_len=7, even parity, frame 0x55 with parity bit 0 -> data_valid, P_DATA=0x055. Repeat with parity bit 1 -> par_err pulse, data_valid=0, P_DATA unchanged.
- two_stop=1, Prescale=16, frame 0x3C with second stop bit 0 -> stp_err pulse, no data_valid. Repeat with both stops 1 -> P_DATA=0x03C.
- S_DATA low for 3 edges only (start glitch), Prescale=16 -> FSM returns to IDLE; no pulses; the next valid frame 0x81 is received correctly.
- S_DATA held low for 2 full frame times, odd parity, data_len=8 -> single brk_det pulse; no stp_err; no further activity until S_DATA high; then a frame 0x12 is received.
- Two back-to-back frames 0xFF then 0x00 with no idle gap, and one noisy single-edge spike at mid-bit -> both data_valid pulses, values correct (majority vote rejects the spike).
